// File: rtl/rvfi_commit_serializer.sv
// Ordered multi-push, single-pop queue serializing parallel RVFI commit records.
// Optional RVFI_SERIALIZER_SEQ_TAG_EN adds a 32-bit retire sequence tag (out_seq_o).

module rvfi_commit_lane #(
  parameter int LW = 4,
  parameter int PW = 3
) (
  input  logic          valid,
  input  logic [LW-1:0] prefix,
  input  logic [LW-1:0] free,
  input  logic [PW-1:0] wr_ptr,
  output logic          accept,
  output logic [PW-1:0] slot
);
  // prefix = number of valid older ports; only the first `free` of them fit
  assign accept = valid && (prefix < free);
  assign slot   = wr_ptr + prefix[PW-1:0];
endmodule

module rvfi_commit_serializer #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DATA_W          = 64,
  parameter int DEPTH           = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_valid_i,
  input  logic [NR_COMMIT_PORTS*DATA_W-1:0] commit_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_W-1:0]                 out_data_o,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic                              overflow_o,
  output logic [15:0]                       drop_cnt_o
`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
  ,
  output logic [31:0]                       out_seq_o
`endif
);
  localparam int NP = NR_COMMIT_PORTS;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [LW-1:0]          level, free, n_valid, n_acc, n_drop;
  logic [NP-1:0][LW-1:0]  prefix;
  logic [NP-1:0]          accept;
  logic [NP-1:0][PW-1:0]  slot;
  logic                   pop;
  logic [16:0]            drop_sum;

  // Space is taken from registered level so out_ready_i never gates acceptance
  assign free = LW'(DEPTH) - level;

  for (genvar p = 0; p < NP; p++) begin : g_lane
    logic [LW-1:0] pre;
    always_comb begin
      pre = '0;
      for (int i = 0; i < p; i++) pre = pre + LW'(commit_valid_i[i]);
    end
    assign prefix[p] = pre;

    rvfi_commit_lane #(.LW(LW), .PW(PW)) u_lane (
      .valid  (commit_valid_i[p]),
      .prefix (pre),
      .free   (free),
      .wr_ptr (wr_ptr),
      .accept (accept[p]),
      .slot   (slot[p])
    );
  end

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NP; i++) n_valid = n_valid + LW'(commit_valid_i[i]);
  end

  // Flush-cycle records are discarded outright, neither accepted nor dropped
  assign n_acc    = flush_i ? '0 : ((n_valid > free) ? free : n_valid);
  assign n_drop   = flush_i ? '0 : (n_valid - n_acc);
  assign pop      = out_valid_o && out_ready_i && !flush_i;
  assign drop_sum = {1'b0, drop_cnt_o} + 17'(n_drop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(n_acc);
        rd_ptr <= rd_ptr + PW'(pop);
        level  <= level + n_acc - LW'(pop);
      end
      if (n_drop != '0) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NP; p++)
      if (accept[p] && !flush_i) mem[slot[p]] <= commit_data_i[p*DATA_W +: DATA_W];
  end

  assign out_valid_o = (level != '0);
  assign out_data_o  = mem[rd_ptr];
  assign level_o     = level;

`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
  logic [31:0] seq_cnt;
  logic [31:0] seq_mem [DEPTH];

  // Every non-flushed valid record takes a number, so drops leave visible gaps
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       seq_cnt <= '0;
    else if (!flush_i) seq_cnt <= seq_cnt + 32'(n_valid);
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NP; p++)
      if (accept[p] && !flush_i) seq_mem[slot[p]] <= seq_cnt + 32'(prefix[p]);
  end

  assign out_seq_o = seq_mem[rd_ptr];
`endif
endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Randomized and directed bench for rvfi_commit_serializer against a queue-based model.
// Define RVFI_SERIALIZER_SEQ_TAG_EN to also check the sequence tag.

module tb_rvfi_commit_serializer;
  localparam int NP    = 2;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i;
  logic [NP-1:0]  commit_valid_i;
  logic [NP*DW-1:0] commit_data_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [DW-1:0]  out_data_o;
  logic [2:0]     level_o;
  logic           overflow_o;
  logic [15:0]    drop_cnt_o;
`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
  logic [31:0]    out_seq_o;
`endif

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .commit_valid_i (commit_valid_i),
    .commit_data_i  (commit_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o)
`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
    ,
    .out_seq_o      (out_seq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic [31:0] s;
  } rec_t;

  rec_t        mq[$];
  int          m_drops;
  logic        m_ovf;
  logic [31:0] m_seq;
  int          checks = 0;
  int          errors = 0;

  function automatic void model_reset();
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    m_seq   = '0;
  endfunction

  // Queue semantics: space counted before the pop, then pop head, then append in port order
  function automatic void model_step(input logic [1:0] v, input logic [63:0] d0, d1,
                                     input logic rdy, input logic fl);
    int   free;
    rec_t r;
    if (fl) begin
      mq.delete();
      return;
    end
    free = DEPTH - mq.size();
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    for (int p = 0; p < NP; p++) begin
      if (v[p]) begin
        if (free > 0) begin
          r.d = (p == 0) ? d0 : d1;
          r.s = m_seq;
          mq.push_back(r);
          free--;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
        m_seq = m_seq + 1;
      end
    end
  endfunction

  task automatic step(input logic [1:0] v, input logic [63:0] d0, d1,
                      input logic rdy, input logic fl);
    commit_valid_i = v;
    commit_data_i  = {d1, d0};
    out_ready_i    = rdy;
    flush_i        = fl;
    @(posedge clk_i);
    model_step(v, d0, d1, rdy, fl);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; commit_valid_i = '0; commit_data_i = '0; out_ready_i = 1'b0;
    model_reset();
    #12 rst_ni = 1'b1;
    #2;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drops got %0d exp 0", drop_cnt_o); end
  endtask

  task automatic test_ordering();
    step(2'b11, 64'hA, 64'hB, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hA) begin errors++; $display("FAIL order_first got v=%b d=%h exp v=1 d=a", out_valid_o, out_data_o); end
    checks++; if (level_o !== 3'd2) begin errors++; $display("FAIL order_lvl2 got %0d exp 2", level_o); end
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hB) begin errors++; $display("FAIL order_second got v=%b d=%h exp v=1 d=b", out_valid_o, out_data_o); end
    checks++; if (level_o !== 3'd1) begin errors++; $display("FAIL order_lvl1 got %0d exp 1", level_o); end
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b0 || level_o !== 3'd0) begin errors++; $display("FAIL order_empty got v=%b lvl=%0d exp v=0 lvl=0", out_valid_o, level_o); end
  endtask

  task automatic test_compaction();
    step(2'b10, 64'h0, 64'hC, 1'b0, 1'b0);
    step(2'b01, 64'hD, 64'h0, 1'b0, 1'b0);
    checks++; if (level_o !== 3'd2 || out_data_o !== 64'hC) begin errors++; $display("FAIL compact_head got lvl=%0d d=%h exp lvl=2 d=c", level_o, out_data_o); end
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hD) begin errors++; $display("FAIL compact_second got v=%b d=%h exp v=1 d=d", out_valid_o, out_data_o); end
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL compact_empty got v=%b exp 0", out_valid_o); end
  endtask

  task automatic test_overflow();
    step(2'b11, 64'h1, 64'h2, 1'b0, 1'b0);
    step(2'b11, 64'h3, 64'h4, 1'b0, 1'b0);
    step(2'b11, 64'h5, 64'h6, 1'b0, 1'b0);
    checks++; if (level_o !== 3'd4 || out_data_o !== 64'h1) begin errors++; $display("FAIL ovf_full got lvl=%0d d=%h exp lvl=4 d=1", level_o, out_data_o); end
    checks++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_count got ovf=%b drops=%0d exp ovf=1 drops=2", overflow_o, drop_cnt_o); end
    // Full plus pop: the new record still finds no room
    step(2'b01, 64'h7, 64'h0, 1'b1, 1'b0);
    checks++; if (level_o !== 3'd3 || out_data_o !== 64'h2) begin errors++; $display("FAIL fullpop_lvl got lvl=%0d d=%h exp lvl=3 d=2", level_o, out_data_o); end
    checks++; if (drop_cnt_o !== 16'd3) begin errors++; $display("FAIL fullpop_drops got %0d exp 3", drop_cnt_o); end
  endtask

  task automatic test_flush();
    step(2'b11, 64'h8, 64'h9, 1'b1, 1'b1);
    checks++; if (level_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear got lvl=%0d v=%b exp lvl=0 v=0", level_o, out_valid_o); end
    checks++; if (drop_cnt_o !== 16'd3 || overflow_o !== 1'b1) begin errors++; $display("FAIL flush_drops got drops=%0d ovf=%b exp drops=3 ovf=1", drop_cnt_o, overflow_o); end
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_nothing got v=%b exp 0", out_valid_o); end
  endtask

  task automatic test_async_reset();
    step(2'b11, 64'h21, 64'h22, 1'b0, 1'b0);
    checks++; if (level_o !== 3'd2 || overflow_o !== 1'b1) begin errors++; $display("FAIL prereset got lvl=%0d ovf=%b exp lvl=2 ovf=1", level_o, overflow_o); end
    #2 rst_ni = 1'b0;
    commit_valid_i = '0;
    model_reset();
    #1;
    checks++; if (out_valid_o !== 1'b0 || level_o !== 3'd0) begin errors++; $display("FAIL areset_q got v=%b lvl=%0d exp v=0 lvl=0", out_valid_o, level_o); end
    checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL areset_ovf got ovf=%b drops=%0d exp 0 0", overflow_o, drop_cnt_o); end
    #1 rst_ni = 1'b1;
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL postreset_idle got v=%b exp 0", out_valid_o); end
    step(2'b10, 64'h0, 64'hE, 1'b0, 1'b0);
    checks++; if (out_valid_o !== 1'b1 || out_data_o !== 64'hE) begin errors++; $display("FAIL postreset_first got v=%b d=%h exp v=1 d=e", out_valid_o, out_data_o); end
  endtask

`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
  task automatic test_seq_tag();
    logic [31:0] base;
    step(2'b00, 64'h0, 64'h0, 1'b0, 1'b1);
    base = m_seq;
    step(2'b11, 64'hA, 64'hB, 1'b0, 1'b0);
    step(2'b11, 64'hA1, 64'hA2, 1'b0, 1'b0);
    step(2'b01, 64'hA3, 64'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_seq_o !== base + 32'(k)) begin errors++; $display("FAIL seq_head%0d got %0d exp %0d", k, out_seq_o, base + 32'(k)); end
      step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    end
    step(2'b01, 64'hC, 64'h0, 1'b0, 1'b0);
    checks++; if (out_data_o !== 64'hC || out_seq_o !== base + 32'd5) begin errors++; $display("FAIL seq_gap got d=%h s=%0d exp d=c s=%0d", out_data_o, out_seq_o, base + 32'd5); end
  endtask
`endif

  task automatic test_random();
    logic [1:0]  v;
    logic [63:0] d0, d1;
    logic        rdy, fl;
    for (int c = 0; c < 400; c++) begin
      v   = 2'($urandom_range(0, 3));
      d0  = {$urandom, $urandom};
      d1  = {$urandom, $urandom};
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 24) == 0);
      step(v, d0, d1, rdy, fl);
      checks++; if (level_o !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level c=%0d got %0d exp %0d", c, level_o, mq.size()); end
      checks++; if (out_valid_o !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, out_valid_o, mq.size() != 0); end
      checks++; if (overflow_o !== m_ovf || drop_cnt_o !== 16'(m_drops)) begin errors++; $display("FAIL rnd_drops c=%0d got ovf=%b n=%0d exp ovf=%b n=%0d", c, overflow_o, drop_cnt_o, m_ovf, m_drops); end
      if (mq.size() != 0) begin
        checks++; if (out_data_o !== mq[0].d) begin errors++; $display("FAIL rnd_data c=%0d got %h exp %h", c, out_data_o, mq[0].d); end
`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
        checks++; if (out_seq_o !== mq[0].s) begin errors++; $display("FAIL rnd_seq c=%0d got %0d exp %0d", c, out_seq_o, mq[0].s); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_compaction();
    test_overflow();
    test_flush();
    test_async_reset();
`ifdef RVFI_SERIALIZER_SEQ_TAG_EN
    test_seq_tag();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
